// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the serial pattern detector.
//   state_e      : detector FSM states (S_FILL while the window is filling,
//                  S_HUNT once it holds a full pattern length of bits)
//   DEF_*        : default parameter values used by seq_detector_p
//   pat_w_legal  : elaboration-time range check for the pattern width
package seq_det_pkg;

  typedef enum logic {
    S_FILL = 1'b0,
    S_HUNT = 1'b1
  } state_e;

  localparam int unsigned DEF_PAT_W   = 3;
  localparam logic [2:0]  DEF_PATTERN = 3'b101;
  localparam int unsigned DEF_OVERLAP = 1;
  localparam int unsigned DEF_CNT_W   = 8;
  localparam int unsigned PAT_W_MIN   = 2;
  localparam int unsigned PAT_W_MAX   = 16;

  function automatic bit pat_w_legal(input int unsigned w);
    return (w >= PAT_W_MIN) && (w <= PAT_W_MAX);
  endfunction

endpackage

// File: rtl/seq_detector_p_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : synchronous clear; applied before inc on the same edge
//   inc          : add one (holds at all-ones)
//   cnt          : registered count
//   sat          : registered flag, high while cnt is all-ones
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         sat_q, sat_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  // Clear first, then count, so a clear coinciding with an increment yields 1.
  always_comb begin
    cnt_d = clr ? '0 : cnt_q;
    if (inc && (cnt_d != '1)) begin
      cnt_d = cnt_d + W'(1);
    end
    sat_d = (cnt_d == '1);
  end

  assign cnt = cnt_q;
  assign sat = sat_q;

endmodule

// File: rtl/seq_detector_p.sv
// Serial bit-pattern detector with runtime-loadable pattern and match counter.
//   clk, reset_n  : clock, asynchronous active-low reset
//   din/din_valid : serial input bit, sampled only when din_valid is high
//   cfg_load      : load cfg_pattern (MSB = first bit) and restart the window
//   cnt_clr       : synchronous clear of match_cnt
//   dout          : registered one-cycle pulse, one cycle after the final bit
//   match_cnt     : saturating match count; cnt_sat high at all-ones
module seq_detector_p
  import seq_det_pkg::*;
#(
  parameter int unsigned      PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter int unsigned      OVERLAP = DEF_OVERLAP,
  parameter int unsigned      CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cnt_clr,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  if (!pat_w_legal(PAT_W)) begin : g_bad_pat_w
    $error("seq_detector_p: PAT_W must be in 2..16");
  end

  localparam int unsigned      FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

  state_e             state_q,   state_d;
  logic [PAT_W-1:0]   window_q,  window_d;
  logic [PAT_W-1:0]   pattern_q, pattern_d;
  logic [FILL_W-1:0]  fill_q,    fill_d;
  logic               dout_q,    dout_d;

  logic [PAT_W-1:0]   window_shift;
  logic               window_full;
  logic               hit;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FILL;
      window_q  <= '0;
      fill_q    <= '0;
      pattern_q <= PATTERN;
      dout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      window_q  <= window_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      dout_q    <= dout_d;
    end
  end

  // Match decode: the compare uses the window as it will look after this
  // edge, so a hit is registered on the same edge that samples the last bit.
  always_comb begin
    window_shift = {window_q[PAT_W-2:0], din};
    window_full  = (state_q == S_HUNT) || (fill_q == FILL_LAST);
    hit          = din_valid && !cfg_load && window_full &&
                   (window_shift == pattern_q);
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    window_d  = window_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    if (cfg_load) begin
      // Restarting the fill count is enough to discard old window contents.
      pattern_d = cfg_pattern;
      fill_d    = '0;
      state_d   = S_FILL;
    end else if (din_valid) begin
      window_d = window_shift;
      if (hit && (OVERLAP == 0)) begin
        fill_d  = '0;
        state_d = S_FILL;
      end else begin
        unique case (state_q)
          S_FILL: begin
            fill_d = fill_q + FILL_W'(1);
            if (fill_q == FILL_LAST) begin
              state_d = S_HUNT;
            end
          end
          S_HUNT: begin
            state_d = S_HUNT;
          end
          default: begin
            state_d = S_FILL;
          end
        endcase
      end
    end
  end

  // Output logic
  always_comb begin
    dout_d = hit;
  end

  assign dout = dout_q;

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (hit),
    .cnt     (match_cnt),
    .sat     (cnt_sat)
  );

endmodule

// File: tb/tb_seq_detector_p.sv
// Bench for seq_detector_p: four instances with different parameter sets share
// one stimulus stream; a bit-history model predicts every output each cycle.
module tb_seq_detector_p;

  localparam int NI = 4;

  logic        clk;
  logic        reset_n;
  logic        din, din_valid, cfg_load, cnt_clr;
  logic [15:0] cfg_pat;

  logic       dout_a, dout_b, dout_c, dout_d;
  logic       sat_a, sat_b, sat_c, sat_d;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic [3:0] cnt_d;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seq_detector_p u_a (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pat[2:0]), .cnt_clr(cnt_clr),
    .dout(dout_a), .match_cnt(cnt_a), .cnt_sat(sat_a));

  seq_detector_p #(.OVERLAP(0)) u_b (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pat[2:0]), .cnt_clr(cnt_clr),
    .dout(dout_b), .match_cnt(cnt_b), .cnt_sat(sat_b));

  seq_detector_p #(.CNT_W(2)) u_c (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pat[2:0]), .cnt_clr(cnt_clr),
    .dout(dout_c), .match_cnt(cnt_c), .cnt_sat(sat_c));

  seq_detector_p #(.PAT_W(5), .PATTERN(5'b11010), .OVERLAP(0), .CNT_W(4)) u_d (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pat[4:0]), .cnt_clr(cnt_clr),
    .dout(dout_d), .match_cnt(cnt_d), .cnt_sat(sat_d));

  // Reference model: per instance, the bits received since the last restart
  // (as an integer history plus a count) and the match count.
  int m_pw   [NI] = '{3, 3, 3, 5};
  int m_def  [NI] = '{5, 5, 5, 26};
  int m_ovl  [NI] = '{1, 0, 1, 0};
  int m_cmax [NI] = '{255, 255, 3, 15};
  int m_pat  [NI];
  int m_hist [NI];
  int m_n    [NI];
  int m_cnt  [NI];
  bit m_dout [NI];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_pat[i]  = m_def[i];
      m_hist[i] = 0;
      m_n[i]    = 0;
      m_cnt[i]  = 0;
      m_dout[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      int mask;
      bit hit;
      mask = (1 << m_pw[i]) - 1;
      hit  = 1'b0;
      if (cfg_load) begin
        m_pat[i] = int'(cfg_pat) & mask;
        m_n[i]   = 0;
      end else if (din_valid) begin
        m_hist[i] = ((m_hist[i] << 1) | int'(din)) & mask;
        if (m_n[i] < m_pw[i]) m_n[i]++;
        if (m_n[i] == m_pw[i] && m_hist[i] == m_pat[i]) begin
          hit = 1'b1;
          if (m_ovl[i] == 0) m_n[i] = 0;
        end
      end
      m_dout[i] = hit;
      if (cnt_clr) m_cnt[i] = 0;
      if (hit && m_cnt[i] < m_cmax[i]) m_cnt[i]++;
    end
  endtask

  task automatic check_all();
    chk("a_dout", 32'(dout_a), 32'(m_dout[0]));
    chk("a_cnt",  32'(cnt_a),  m_cnt[0]);
    chk("a_sat",  32'(sat_a),  32'(m_cnt[0] == m_cmax[0]));
    chk("b_dout", 32'(dout_b), 32'(m_dout[1]));
    chk("b_cnt",  32'(cnt_b),  m_cnt[1]);
    chk("b_sat",  32'(sat_b),  32'(m_cnt[1] == m_cmax[1]));
    chk("c_dout", 32'(dout_c), 32'(m_dout[2]));
    chk("c_cnt",  32'(cnt_c),  m_cnt[2]);
    chk("c_sat",  32'(sat_c),  32'(m_cnt[2] == m_cmax[2]));
    chk("d_dout", 32'(dout_d), 32'(m_dout[3]));
    chk("d_cnt",  32'(cnt_d),  m_cnt[3]);
    chk("d_sat",  32'(sat_d),  32'(m_cnt[3] == m_cmax[3]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic send(input bit d);
    din_valid = 1'b1;
    din       = d;
    tick();
    cfg_load  = 1'b0;
    cnt_clr   = 1'b0;
  endtask

  task automatic idle();
    din_valid = 1'b0;
    din       = 1'b1;
    tick();
  endtask

  // Called just after a clock edge; holds reset across one edge.
  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b1;
    din       = 1'b0;
    din_valid = 1'b0;
    cfg_load  = 1'b0;
    cnt_clr   = 1'b0;
    cfg_pat   = '0;
    #3;
    do_reset();

    // 1,0,1,0,1: overlapping vs restarting window
    send(1'b1); send(1'b0);
    chk("s33_nofill", 32'(dout_a), 32'd0);
    send(1'b1);
    chk("s33_a_p1", 32'(dout_a), 32'd1);
    chk("s33_b_p1", 32'(dout_b), 32'd1);
    send(1'b0);
    chk("s33_a_gap", 32'(dout_a), 32'd0);
    send(1'b1);
    chk("s33_a_p2", 32'(dout_a), 32'd1);
    chk("s33_b_p2", 32'(dout_b), 32'd0);
    chk("s33_a_cnt", 32'(cnt_a), 32'd2);
    chk("s34_b_cnt", 32'(cnt_b), 32'd1);

    // Saturation of the 2-bit counter, then clear coincident with a hit
    send(1'b0); send(1'b1);
    chk("s38_c_cnt3", 32'(cnt_c), 32'd3);
    chk("s38_c_sat",  32'(sat_c), 32'd1);
    send(1'b0); send(1'b1);
    chk("s38_c_hold", 32'(cnt_c), 32'd3);
    send(1'b0);
    cnt_clr = 1'b1;
    send(1'b1);
    chk("s38_c_clrhit", 32'(cnt_c), 32'd1);
    chk("s38_c_dout",   32'(dout_c), 32'd1);
    chk("s38_c_unsat",  32'(sat_c), 32'd0);

    // Invalid cycles hold the window
    do_reset();
    send(1'b1); send(1'b0);
    idle();
    chk("s35_idle1", 32'(dout_a), 32'd0);
    idle();
    chk("s35_idle2", 32'(dout_a), 32'd0);
    send(1'b1);
    chk("s35_pulse", 32'(dout_a), 32'd1);

    // Runtime pattern load; din on the load edge is discarded
    cfg_load = 1'b1;
    cfg_pat  = 16'b110;
    send(1'b1);
    chk("s36_load", 32'(dout_a), 32'd0);
    send(1'b1); send(1'b1);
    chk("s36_early", 32'(dout_a), 32'd0);
    send(1'b0);
    chk("s36_hit", 32'(dout_a), 32'd1);
    send(1'b1); chk("s36_n1", 32'(dout_a), 32'd0);
    send(1'b0); chk("s36_n2", 32'(dout_a), 32'd0);
    send(1'b1); chk("s36_n3", 32'(dout_a), 32'd0);

    // Reset mid-sequence discards progress
    do_reset();
    send(1'b1); send(1'b0);
    reset_n = 1'b0;
    #2;
    model_reset();
    chk("s37_rst_dout", 32'(dout_a), 32'd0);
    chk("s37_rst_cnt",  32'(cnt_a),  32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    send(1'b1);
    chk("s37_nopulse", 32'(dout_a), 32'd0);
    check_all();

    // Randomised traffic
    for (int k = 0; k < 3000; k++) begin
      din       = 1'($urandom_range(0, 1));
      din_valid = ($urandom_range(0, 3) != 0);
      cfg_load  = ($urandom_range(0, 39) == 0);
      cfg_pat   = 16'($urandom);
      cnt_clr   = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
